// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS memory-access stage.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } memst_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } memkind_t;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_timeout.sv
// Bus-wait watchdog: counts BUSY cycles and flags expiry once TIMEOUT is reached.
// Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == CW'(TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mips_mem_ctrl.sv
// Memory-access stage: turns decoder fetch/load/store requests into single bus
// transactions and owns IR/MDR. Optional bus timeout enabled by MEM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a request; misaligned requests flag err and skip the bus
// BUSY  | bus_valid high, address/data held until bus_ready (or timeout)
// DONE  | one-cycle completion slot; stall released so the controller advances
module mips_mem_ctrl
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] aluout,
    input  logic [31:0]       wd,
    input  logic              iord,
    input  logic              irwrite,
    input  logic              memread,
    input  logic              memwrite,
    output logic [31:0]       instr,
    output logic [31:0]       data,
    output logic              stall,
    output logic              err,
    output logic [ADDR_W-3:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic              bus_we,
    output logic              bus_valid,
    input  logic              bus_ready,
    input  logic [31:0]       bus_rdata
);

    memst_t            state_q, state_d;
    memkind_t          kind_q, kind_d, req_kind;
    logic [ADDR_W-3:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       data_q, data_d;
    logic              err_q, err_d;
    logic              req, aligned, valid_c, tmo_expired;
    logic [ADDR_W-1:0] addr_sel;

    assign req      = irwrite | memread | memwrite;
    assign addr_sel = iord ? aluout : pc;
    assign aligned  = (addr_sel[1:0] == 2'b00);
    assign req_kind = memwrite ? STORE : (irwrite ? FETCH : LOAD);

`ifdef MEM_TIMEOUT_EN
    logic tmo_clr;
    assign tmo_clr = (state_q == IDLE) && req && aligned;

    mem_timeout #(.TIMEOUT(TIMEOUT)) u_mem_timeout (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (tmo_clr),
        .en_i      (state_q == BUSY),
        .expired_o (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        instr_d = instr_q;
        data_d  = data_q;
        err_d   = err_q;
        valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (!aligned) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_sel[ADDR_W-1:2];
                        wdata_d = wd;
                        kind_d  = req_kind;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (tmo_expired) begin
                    // Abort: poison the destination register so the fault is visible.
                    err_d   = 1'b1;
                    state_d = DONE;
                    case (kind_q)
                        FETCH:   instr_d = TIMEOUT_FILL;
                        LOAD:    data_d  = TIMEOUT_FILL;
                        default: ;
                    endcase
                end else begin
                    valid_c = 1'b1;
                    if (bus_ready) begin
                        state_d = DONE;
                        case (kind_q)
                            FETCH:   instr_d = bus_rdata;
                            LOAD:    data_d  = bus_rdata;
                            default: ;
                        endcase
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            kind_q  <= FETCH;
            addr_q  <= '0;
            wdata_q <= '0;
            instr_q <= NOP_INSTR;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            instr_q <= instr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign instr     = instr_q;
    assign data      = data_q;
    assign err       = err_q;
    assign stall     = req && (state_q != DONE);
    assign bus_valid = valid_c;
    assign bus_we    = valid_c && (kind_q == STORE);
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_mips_mem_ctrl.sv
// Directed, table-driven bench for mips_mem_ctrl; timeout sequence runs only
// when MEM_TIMEOUT_EN is defined.
module tb_mips_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, aluout, wd, bus_rdata;
    logic        iord, irwrite, memread, memwrite, bus_ready;
    logic [31:0] instr, data, bus_wdata;
    logic [29:0] bus_addr;
    logic        stall, err, bus_we, bus_valid;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mips_mem_ctrl #(.ADDR_W(32), .TIMEOUT(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .aluout    (aluout),
        .wd        (wd),
        .iord      (iord),
        .irwrite   (irwrite),
        .memread   (memread),
        .memwrite  (memwrite),
        .instr     (instr),
        .data      (data),
        .stall     (stall),
        .err       (err),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata)
    );

    typedef struct {
        logic        iord, irw, mrd, mwr;
        logic [31:0] pc, alu, wd, rdata;
        int          waits;
        bit          misal;
        logic [31:0] e_instr, e_data, e_addr;
        logic        e_we, e_err;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drop_req();
        irwrite = 0; memread = 0; memwrite = 0; bus_ready = 0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string p;
        p = $sformatf("v%0d", idx);
        @(negedge clk);
        iord = v.iord; irwrite = v.irw; memread = v.mrd; memwrite = v.mwr;
        pc = v.pc; aluout = v.alu; wd = v.wd; bus_ready = 0; bus_rdata = 32'h0;
        #1;
        chk({p, "_stall_n"}, {31'b0, stall}, 32'd1);
        chk({p, "_valid_n"}, {31'b0, bus_valid}, 32'd0);
        if (v.misal) begin
            @(negedge clk);
            chk({p, "_stall_done"}, {31'b0, stall}, 32'd0);
            chk({p, "_valid_done"}, {31'b0, bus_valid}, 32'd0);
        end else begin
            for (int c = 0; c <= v.waits; c++) begin
                @(negedge clk);
                chk($sformatf("%s_valid_b%0d", p, c), {31'b0, bus_valid}, 32'd1);
                chk($sformatf("%s_stall_b%0d", p, c), {31'b0, stall}, 32'd1);
                chk($sformatf("%s_addr_b%0d", p, c), {2'b0, bus_addr}, v.e_addr);
                chk($sformatf("%s_we_b%0d", p, c), {31'b0, bus_we}, {31'b0, v.e_we});
                chk($sformatf("%s_wdata_b%0d", p, c), bus_wdata, v.wd);
                bus_ready = (c == v.waits);
                bus_rdata = (c == v.waits) ? v.rdata : 32'hBAD0_0BAD;
            end
            @(negedge clk);
            bus_ready = 0;
            chk({p, "_stall_done"}, {31'b0, stall}, 32'd0);
            chk({p, "_valid_done"}, {31'b0, bus_valid}, 32'd0);
        end
        chk({p, "_instr"}, instr, v.e_instr);
        chk({p, "_data"}, data, v.e_data);
        chk({p, "_err"}, {31'b0, err}, {31'b0, v.e_err});
        drop_req();
        @(negedge clk);
        chk({p, "_idle_stall"}, {31'b0, stall}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //          iord irw mrd mwr  pc            alu           wd            rdata         w  mis  instr         data          addr          we   err
        vt[0] = '{1'b0,1'b1,1'b0,1'b0, 32'h0000_0040, 32'h0,        32'h0,        32'h8C01_0004, 0, 1'b0, 32'h8C01_0004, 32'h0,        32'h10,       1'b0,1'b0};
        vt[1] = '{1'b1,1'b0,1'b1,1'b0, 32'h0,         32'h0000_0100, 32'h0,        32'hCAFE_0001, 3, 1'b0, 32'h8C01_0004, 32'hCAFE_0001, 32'h40,       1'b0,1'b0};
        vt[2] = '{1'b1,1'b1,1'b0,1'b1, 32'h0,         32'h0000_0008, 32'h1234_5678, 32'hFFFF_FFFF, 1, 1'b0, 32'h8C01_0004, 32'hCAFE_0001, 32'h2,        1'b1,1'b0};
        vt[3] = '{1'b0,1'b1,1'b1,1'b0, 32'h0000_1000, 32'h0,        32'h0,        32'h2002_0005, 0, 1'b0, 32'h2002_0005, 32'hCAFE_0001, 32'h400,      1'b0,1'b0};
        vt[4] = '{1'b0,1'b0,1'b1,1'b0, 32'h0000_0044, 32'h0,        32'h0,        32'h1111_2222, 2, 1'b0, 32'h2002_0005, 32'h1111_2222, 32'h11,       1'b0,1'b0};
        vt[5] = '{1'b1,1'b0,1'b1,1'b0, 32'h0,         32'h0000_0102, 32'h0,        32'h0,        0, 1'b1, 32'h2002_0005, 32'h1111_2222, 32'h0,        1'b0,1'b1};
        vt[6] = '{1'b0,1'b1,1'b0,1'b0, 32'h0000_0041, 32'h0,        32'h0,        32'h0,        0, 1'b1, 32'h2002_0005, 32'h1111_2222, 32'h0,        1'b0,1'b1};

        reset = 0; pc = 0; aluout = 0; wd = 0; iord = 0; bus_rdata = 0;
        drop_req();
        repeat (2) @(negedge clk);
        chk("rst_instr", instr, 32'h0);
        chk("rst_data", data, 32'h0);
        chk("rst_valid", {31'b0, bus_valid}, 32'd0);
        chk("rst_we", {31'b0, bus_we}, 32'd0);
        chk("rst_addr", {2'b0, bus_addr}, 32'h0);
        chk("rst_wdata", bus_wdata, 32'h0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        reset = 1;

        for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

        // Request dropped mid-BUSY: transaction must still complete; err stays sticky.
        @(negedge clk);
        iord = 1; aluout = 32'h200; memread = 1;
        @(negedge clk);
        chk("drop_valid0", {31'b0, bus_valid}, 32'd1);
        memread = 0;
        #1;
        chk("drop_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        chk("drop_valid1", {31'b0, bus_valid}, 32'd1);
        chk("drop_addr", {2'b0, bus_addr}, 32'h80);
        bus_ready = 1; bus_rdata = 32'h5555_AAAA;
        @(negedge clk);
        bus_ready = 0;
        chk("drop_done_valid", {31'b0, bus_valid}, 32'd0);
        chk("drop_data", data, 32'h5555_AAAA);
        chk("drop_err_sticky", {31'b0, err}, 32'd1);
        @(negedge clk);

        // Reset while BUSY abandons the fetch.
        iord = 0; pc = 32'h40; irwrite = 1;
        @(negedge clk);
        chk("rstb_valid_pre", {31'b0, bus_valid}, 32'd1);
        reset = 0;
        @(negedge clk);
        chk("rstb_valid", {31'b0, bus_valid}, 32'd0);
        chk("rstb_instr", instr, 32'h0);
        chk("rstb_data", data, 32'h0);
        chk("rstb_err", {31'b0, err}, 32'd0);
        chk("rstb_stall", {31'b0, stall}, 32'd1);
        chk("rstb_addr", {2'b0, bus_addr}, 32'h0);
        reset = 1; irwrite = 0;
        @(negedge clk);

`ifdef MEM_TIMEOUT_EN
        begin
            int vcnt;
            int guard;
            vcnt = 0; guard = 0;
            pc = 32'h80; iord = 0; irwrite = 1; bus_ready = 0;
            @(negedge clk);
            while (bus_valid && guard < 40) begin
                vcnt++; guard++;
                @(negedge clk);
            end
            chk("tmo_valid_cycles", vcnt, 32'd15);
            guard = 0;
            while (stall && guard < 10) begin
                guard++;
                @(negedge clk);
            end
            chk("tmo_reached_done", {31'b0, stall}, 32'd0);
            chk("tmo_instr", instr, 32'hDEAD_BEEF);
            chk("tmo_err", {31'b0, err}, 32'd1);
            irwrite = 0;
            @(negedge clk);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mips_mem_ctrl.md
# mips_mem_ctrl

- Memory-access stage directly downstream of the multicycle main decoder.
- Consumes `iord`, `irwrite`, `memread` and `memwrite` and turns each into one transaction on a single-port word-addressed memory bus.
- Owns the instruction register (IR) and memory data register (MDR), which it feeds back to the datapath.
- Asserts `stall` so the controller holds its current state until the access completes.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width on the datapath side.
- `TIMEOUT`, 15: cycles waited for `bus_ready` before abort (used only with `MEM_TIMEOUT_EN`).

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-low; `reset`=0 resets the block on a rising `clk`.
- `pc` in ADDR_W: instruction fetch address.
- `aluout` in ADDR_W: data address.
- `wd` in 32: store data (rt).
- `iord` in 1: 0 selects `pc`, 1 selects `aluout`.
- `irwrite` in 1: fetch request; read data is loaded into IR.
- `memread` in 1: load request; read data is loaded into MDR.
- `memwrite` in 1: store request.
- `instr` out 32: IR contents.
- `data` out 32: MDR contents.
- `stall` out 1: controller must hold its state and its request inputs.
- `err` out 1: sticky error flag (misaligned access, or timeout).
- `bus_addr` out ADDR_W-2: word address.
- `bus_wdata` out 32: write data.
- `bus_we` out 1: write enable.
- `bus_valid` out 1: request valid.
- `bus_ready` in 1: memory accepts/completes the request.
- `bus_rdata` in 32: read data, valid when `bus_valid & bus_ready`.

## Operation
- `req` = `irwrite | memread | memwrite`.
- Address = `iord ? aluout : pc`. `bus_addr` = address[ADDR_W-1:2].
- Priority when several requests are high: `memwrite` > `irwrite` > `memread`. Only one access is performed per request.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - `req`=1 and address[1:0]=0: latch address, `wd` and kind; go to BUSY.
  - `req`=1 and address[1:0]≠0: set `err`, no bus cycle; go to DONE.
- BUSY:
  - `bus_valid`=1; `bus_addr`, `bus_we` and `bus_wdata` are held stable.
  - On `bus_valid & bus_ready`: a read loads `bus_rdata` into IR (fetch) or MDR (load); go to DONE.
- DONE: one cycle; go to IDLE.
- `stall` = `req & (state != DONE)`, combinational.
- IR and MDR change only on a completed read. A write leaves both unchanged.
- `err` is cleared only by reset.
- Requests deasserted while in BUSY are ignored; the transaction still completes.

## Timing
- Reset values:
  - state IDLE.
  - `instr`=0 (NOP), `data`=0.
  - `bus_valid`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0.
  - `err`=0.
- Reset during BUSY: `bus_valid` drops at that edge; the transaction is abandoned with no register update.
- Request first seen in cycle N:
  - `bus_valid` rises in N+1.
  - With zero-wait memory (`bus_ready` high in N+1), IR/MDR are updated at the end of N+1.
  - DONE in N+2; `stall` is low in N+2. Minimum 3 cycles per access.
- Each wait state adds one cycle.
- Misaligned access: DONE in N+1, `stall` low in N+1.
- `instr` and `data` are registered outputs, valid from the cycle after capture.
- Back-to-back requests: a new request is accepted in IDLE, i.e. at the earliest one cycle after DONE.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT+1) runs in BUSY and is cleared on entry to BUSY.
  - When the counter reaches TIMEOUT without `bus_ready`, abort: `bus_valid`=0, `err` set, and a read writes 32'hDEAD_BEEF to the target register. Go to DONE.
- `MEM_TIMEOUT_EN` undefined: no counter; BUSY waits indefinitely.

## Structure
- Package `mips_pkg` holds:
  - the FSM state enum `memst_t` {IDLE, BUSY, DONE};
  - the request-kind enum {FETCH, LOAD, STORE};
  - constants NOP_INSTR=32'h0 and TIMEOUT_FILL=32'hDEAD_BEEF.
- Optional sub-module `mem_timeout`: counter plus expiry flag, instantiated only under `MEM_TIMEOUT_EN`.

## Test plan
- Fetch with zero-wait memory:
  - Stimulus: `pc`=0x40, `irwrite`=1, `bus_rdata`=0x8C01_0004.
  - Response: `bus_addr`=0x10 in N+1; `instr`=0x8C01_0004 from N+2; `stall` high N..N+1, low in N+2.
- Load with 3 wait states:
  - Stimulus: `iord`=1, `aluout`=0x100, `memread`=1.
  - Response: `bus_valid` held for 4 cycles with stable address 0x40; `data` updated; `instr` unchanged.
- Store:
  - Stimulus: `aluout`=0x8, `wd`=0x1234_5678, `memwrite`=1, `irwrite`=1 simultaneously.
  - Response: `bus_we`=1, `bus_wdata`=0x1234_5678; IR unchanged.
- Misaligned access:
  - Stimulus: `aluout`=0x102, `memread`=1.
  - Response: no `bus_valid`; `err`=1; `stall` low in N+1; `data` unchanged.
- Reset mid-BUSY:
  - Stimulus: `reset`=0 while `bus_valid`=1.
  - Response: next cycle `bus_valid`=0, `instr`=0, `data`=0, `stall`=`req`.
- Timeout, with `MEM_TIMEOUT_EN` and TIMEOUT=15:
  - Stimulus: `bus_ready` tied low, fetch request.
  - Response: abort after 15 BUSY cycles; `instr`=0xDEAD_BEEF; `err`=1.
